// File: rtl/spi_master_gen.sv
// spi_master_gen: parametrised SPI master for register-map access.
// Shifts {header, address, data} MSB-first on mosi and returns the last
// DATA_W miso bits on rx_data. Runtime CPOL/CPHA and clock divide,
// one-hot-low chip selects, CS setup/hold timing and an inter-frame gap.
// Ports:
//   clk, reset                    system clock, async active-high reset
//   start, ready, busy, done      request handshake
//   sel_err                       pulse when start names a missing slave
//   cpol, cpha, div, cs_sel, tx_* frame configuration, latched at start
//   rx_data                       payload captured by the last frame
//   sclk, cs_n, mosi, miso        SPI pins
module spi_master_gen #(
  parameter int unsigned HDR_W    = 2,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_CS   = 3,
  parameter int unsigned CS_IDX_W = 2,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned GAP      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [DIV_W-1:0]    div,
  input  logic [CS_IDX_W-1:0] cs_sel,
  input  logic [HDR_W-1:0]    tx_header,
  input  logic [ADDR_W-1:0]   tx_addr,
  input  logic [DATA_W-1:0]   tx_data,
  output logic [DATA_W-1:0]   rx_data,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                sel_err,
  output logic                sclk,
  output logic [NUM_CS-1:0]   cs_n,
  output logic                mosi,
  input  logic                miso
);

  localparam int unsigned PKT     = HDR_W + ADDR_W + DATA_W;
  localparam int unsigned EDGES   = 2 * PKT;
  localparam int unsigned ECNT_W  = $clog2(EDGES + 1);
  localparam int unsigned TMR_MAX = (CS_SETUP > CS_HOLD) ?
                                    ((CS_SETUP > GAP) ? CS_SETUP : GAP) :
                                    ((CS_HOLD > GAP) ? CS_HOLD : GAP);
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE, S_GAP
  } state_t;

  state_t              state;
  logic [PKT-1:0]      tx_shift;
  logic [DATA_W-1:0]   rx_shift;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    hcnt;
  logic [ECNT_W-1:0]   edge_cnt;
  logic [TMR_W-1:0]    tmr;
  logic                cpol_q;
  logic                cpha_q;

  // edge_cnt holds the number of edges already produced, so the edge about
  // to be produced is edge_cnt+1; its bit index is edge_cnt>>1 in both modes.
  logic half_wrap_c;
  logic last_edge_c;
  logic sample_c;
  logic shift_c;
  logic in_payload_c;

  assign half_wrap_c  = (hcnt == DIV_W'(div_q - DIV_W'(1)));
  assign last_edge_c  = (edge_cnt == ECNT_W'(EDGES - 1));
  assign sample_c     = cpha_q ? edge_cnt[0] : ~edge_cnt[0];
  assign shift_c      = cpha_q ? (~edge_cnt[0] && (edge_cnt != '0))
                               : (edge_cnt[0] && !last_edge_c);
  assign in_payload_c = ((edge_cnt >> 1) >= ECNT_W'(PKT - DATA_W));

  // mosi comes straight from the MSB flop of the shift register
  assign mosi = tx_shift[PKT-1];

  // Frame sequencer: setup, 2*PKT sclk edges, hold, done, inter-frame gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      div_q    <= DIV_W'(1);
      hcnt     <= '0;
      edge_cnt <= '0;
      tmr      <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sel_err  <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= '1;
    end else begin
      done    <= 1'b0;
      sel_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (32'(cs_sel) < NUM_CS) begin
              state    <= S_SETUP;
              ready    <= 1'b0;
              busy     <= 1'b1;
              cs_n     <= ~(NUM_CS'(1) << cs_sel);
              sclk     <= cpol;
              cpol_q   <= cpol;
              cpha_q   <= cpha;
              div_q    <= (div == '0) ? DIV_W'(1) : div;
              tx_shift <= {tx_header, tx_addr, tx_data};
              rx_shift <= '0;
              tmr      <= TMR_W'(CS_SETUP - 1);
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (tmr == '0) begin
            state    <= S_XFER;
            hcnt     <= '0;
            edge_cnt <= '0;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_XFER: begin
          if (half_wrap_c) begin
            hcnt     <= '0;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + ECNT_W'(1);
            if (sample_c && in_payload_c)
              rx_shift <= {rx_shift[DATA_W-2:0], miso};
            if (shift_c)
              tx_shift <= {tx_shift[PKT-2:0], 1'b0};
            if (last_edge_c) begin
              state <= S_HOLD;
              tmr   <= TMR_W'(CS_HOLD - 1);
            end
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end
        S_HOLD: begin
          sclk <= cpol_q;
          if (tmr == '0) begin
            state    <= S_DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cs_n     <= '1;
            rx_data  <= rx_shift;
            tx_shift <= '0;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_DONE: begin
          if (GAP == 0) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else begin
            state <= S_GAP;
            tmr   <= TMR_W'(GAP - 1);
          end
        end
        S_GAP: begin
          if (tmr == '0) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen with a behavioural SPI slave that
// records mosi on its sampling edges and drives a known word on miso.
module tb_spi_master_gen;

  localparam int unsigned PKT = 17;
  localparam int unsigned GAP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cpol;
  logic       cpha;
  logic [7:0] div;
  logic [1:0] cs_sel;
  logic [1:0] tx_header;
  logic [6:0] tx_addr;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       ready;
  logic       busy;
  logic       done;
  logic       sel_err;
  logic       sclk;
  logic [2:0] cs_n;
  logic       mosi;
  logic       miso = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .div       (div),
    .cs_sel    (cs_sel),
    .tx_header (tx_header),
    .tx_addr   (tx_addr),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sel_err   (sel_err),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  // Slave model, evaluated mid-cycle on the registered pin values
  logic          m_cpol = 1'b0;
  logic          m_cpha = 1'b0;
  logic [PKT-1:0] s_tx  = '0;
  logic [PKT-1:0] s_sh  = '0;
  logic [PKT-1:0] s_rx  = '0;
  int            s_edges  = 0;
  int            mosi_bad = 0;
  logic          prev_sclk = 1'b0;
  logic          prev_mosi = 1'b0;
  logic [2:0]    prev_cs   = 3'b111;

  always @(negedge clk) begin
    if (cs_n != 3'b111 && prev_cs == 3'b111) begin
      s_edges  = 0;
      s_rx     = '0;
      mosi_bad = 0;
      s_sh     = s_tx;
      miso     = s_sh[PKT-1];
    end else if (cs_n != 3'b111 && sclk != prev_sclk) begin
      s_edges++;
      if ((sclk != m_cpol) ^ m_cpha) begin
        s_rx = {s_rx[PKT-2:0], mosi};
        if (mosi != prev_mosi) mosi_bad++;
      end else if (!(m_cpha && s_edges == 1)) begin
        s_sh = {s_sh[PKT-2:0], 1'b0};
        miso = s_sh[PKT-1];
      end
    end
    prev_sclk = sclk;
    prev_cs   = cs_n;
    prev_mosi = mosi;
  end

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] div;
    logic [1:0] sel;
    logic [1:0] hdr;
    logic [6:0] addr;
    logic [7:0] data;
    logic [16:0] s_tx;
    logic [2:0] exp_cs;
    int         exp_lat;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] last_rx = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(ready), 32'd1);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int lat;
    int cs_bad;
    wait_ready(tag);
    m_cpol = v.cpol; m_cpha = v.cpha; s_tx = v.s_tx;
    cpol = v.cpol; cpha = v.cpha; div = v.div; cs_sel = v.sel;
    tx_header = v.hdr; tx_addr = v.addr; tx_data = v.data;
    start = 1'b1;
    step();
    start = 1'b0;
    // scramble every input mid-frame; the frame must not notice
    cpol = ~v.cpol; cpha = ~v.cpha; div = 8'd7; cs_sel = ~v.sel;
    tx_header = ~v.hdr; tx_addr = ~v.addr; tx_data = ~v.data;
    chk({tag, "_cs_t1"},   32'(cs_n),    32'(v.exp_cs));
    chk({tag, "_busy_t1"}, 32'(busy),    32'd1);
    chk({tag, "_rdy_t1"},  32'(ready),   32'd0);
    chk({tag, "_sclk_t1"}, 32'(sclk),    32'(v.cpol));
    chk({tag, "_rxhold"},  32'(rx_data), 32'(last_rx));
    lat = 1;
    cs_bad = 0;
    while (!done && lat < v.exp_lat + 20) begin
      if (cs_n != v.exp_cs) cs_bad++;
      step();
      lat++;
    end
    chk({tag, "_latency"},  lat,             v.exp_lat);
    chk({tag, "_rx_data"},  32'(rx_data),    32'(v.exp_rx));
    chk({tag, "_cs_done"},  32'(cs_n),       32'h7);
    chk({tag, "_busy_dn"},  32'(busy),       32'd0);
    chk({tag, "_sclk_idl"}, 32'(sclk),       32'(v.cpol));
    chk({tag, "_edges"},    s_edges,         2 * PKT);
    chk({tag, "_mosi_bits"}, 32'(s_rx),      32'({v.hdr, v.addr, v.data}));
    chk({tag, "_mosi_stab"}, mosi_bad,       0);
    chk({tag, "_cs_frame"}, cs_bad,          0);
    last_rx = v.exp_rx;
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  // Backstop in case a wait is ever mis-bounded
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int cnt_a;
    int cnt_b;
    int cnt_c;
    logic sclk0;

    vecs[0] = '{1'b0, 1'b0, 8'd5,   2'd0, 2'b10, 7'h55, 8'hA5, {9'h1FF, 8'h5A}, 3'b110, 175,  8'h5A};
    vecs[1] = '{1'b1, 1'b1, 8'd2,   2'd1, 2'b01, 7'h12, 8'h34, {9'h0AA, 8'h3C}, 3'b101, 73,   8'h3C};
    vecs[2] = '{1'b0, 1'b1, 8'd1,   2'd2, 2'b11, 7'h7F, 8'h00, {9'h155, 8'hC3}, 3'b011, 39,   8'hC3};
    vecs[3] = '{1'b1, 1'b0, 8'd1,   2'd0, 2'b00, 7'h01, 8'hFF, {9'h000, 8'h81}, 3'b110, 39,   8'h81};
    vecs[4] = '{1'b0, 1'b0, 8'd0,   2'd1, 2'b01, 7'h2A, 8'h69, {9'h0F0, 8'h96}, 3'b101, 39,   8'h96};
    vecs[5] = '{1'b0, 1'b1, 8'd3,   2'd2, 2'b10, 7'h40, 8'h0F, {9'h1AB, 8'hE7}, 3'b011, 107,  8'hE7};
    vecs[6] = '{1'b1, 1'b1, 8'd255, 2'd0, 2'b11, 7'h33, 8'hC8, {9'h07E, 8'h42}, 3'b110, 8675, 8'h42};

    reset = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; div = 8'd1; cs_sel = 2'd0;
    tx_header = '0; tx_addr = '0; tx_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();

    // reset values
    chk("rst_sclk",    32'(sclk),    32'd0);
    chk("rst_cs_n",    32'(cs_n),    32'h7);
    chk("rst_mosi",    32'(mosi),    32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_ready",   32'(ready),   32'd1);

    for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // out-of-range chip select
    wait_ready("sel");
    sclk0 = sclk;
    cs_sel = 2'd3; start = 1'b1;
    step();
    start = 1'b0; cs_sel = 2'd0;
    chk("sel_err_pulse", 32'(sel_err), 32'd1);
    chk("sel_cs_n",      32'(cs_n),    32'h7);
    chk("sel_busy",      32'(busy),    32'd0);
    chk("sel_ready",     32'(ready),   32'd1);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (sel_err) cnt_a++;
      if (sclk != sclk0) cnt_b++;
      if (busy || cs_n != 3'b111) cnt_c++;
    end
    chk("sel_err_once",  cnt_a, 0);
    chk("sel_no_sclk",   cnt_b, 0);
    chk("sel_idle",      cnt_c, 0);

    // start held high: one frame per done+GAP
    wait_ready("held");
    m_cpol = 1'b0; m_cpha = 1'b0; s_tx = 17'h0BEEF;
    cpol = 1'b0; cpha = 1'b0; div = 8'd1; cs_sel = 2'd0;
    tx_header = 2'b01; tx_addr = 7'h0F; tx_data = 8'hF0;
    start = 1'b1;
    step();
    c = 1; cnt_a = 0;
    while (!done && c < 100) begin
      if (ready) cnt_a++;
      step();
      c++;
    end
    chk("held_lat1",     c,            39);
    chk("held_rdy_low",  cnt_a,        0);
    chk("held_rx",       32'(rx_data), 32'hEF);
    for (int k = 1; k <= int'(GAP); k++) begin
      step();
      chk($sformatf("held_gap%0d_ready", k), 32'(ready), 32'd0);
      chk($sformatf("held_gap%0d_cs", k),    32'(cs_n),  32'h7);
    end
    step();
    chk("held_idle_ready", 32'(ready), 32'd1);
    chk("held_idle_busy",  32'(busy),  32'd0);
    step();
    chk("held_setup_busy", 32'(busy),  32'd1);
    chk("held_setup_cs",   32'(cs_n),  32'h6);
    chk("held_setup_rdy",  32'(ready), 32'd0);
    c = int'(GAP) + 2;
    while (!done && c < 100) begin
      step();
      c++;
    end
    start = 1'b0;
    chk("held_lat2",       c,                 int'(GAP) + 1 + 39);
    chk("held_mosi_bits",  32'(s_rx),         32'({2'b01, 7'h0F, 8'hF0}));
    last_rx = 8'hEF;

    // reset in the middle of XFER
    wait_ready("mid");
    m_cpol = 1'b0; m_cpha = 1'b0; s_tx = vecs[0].s_tx;
    cpol = 1'b0; cpha = 1'b0; div = 8'd5; cs_sel = 2'd2;
    tx_header = 2'b11; tx_addr = 7'h11; tx_data = 8'h22;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    chk("mid_busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_sclk",    32'(sclk),    32'd0);
    chk("mid_cs_n",    32'(cs_n),    32'h7);
    chk("mid_mosi",    32'(mosi),    32'd0);
    chk("mid_busy",    32'(busy),    32'd0);
    chk("mid_done",    32'(done),    32'd0);
    chk("mid_sel_err", 32'(sel_err), 32'd0);
    chk("mid_rx_data", 32'(rx_data), 32'd0);
    chk("mid_ready",   32'(ready),   32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_rx = 8'h00;
    run_frame(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
